my_seg7_scan: RTL and testbench

MY_SEG7_SCAN -- requirements
Module: my_seg7_scan

---
 rtl/my_seg7_pkg.sv | 12 +
 rtl/my_seg7_if.sv | 25 ++
 rtl/my_seg7_dec.sv | 15 +
 rtl/my_seg7_defs.vh | 38 +++
 rtl/my_seg7_scan.sv | 138 +++++++++++++
 tb/tb_my_seg7_scan.sv | 350 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/my_seg7_pkg.sv
// Shared types and helpers for the seg7 scan block.
// Pulls in the common segment pattern header.
package my_seg7_pkg;

  `include "my_seg7_defs.vh"

  // Digit index width; a single digit still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/my_seg7_if.sv
// Display bus: value/control in, panel drive out.
// master = host side, slave = scan engine.
interface my_seg7_if #(
  parameter int N = 4
);
  logic           en;
  logic [4*N-1:0] num;
  logic [N-1:0]   dp_in;
  logic [3:0]     bright;
  logic           lzb;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   dig;
  logic           frame_tick;

  modport master (
    output en, num, dp_in, bright, lzb,
    input  seg, dp, dig, frame_tick
  );

  modport slave (
    input  en, num, dp_in, bright, lzb,
    output seg, dp, dig, frame_tick
  );
endinterface

// File: rtl/my_seg7_dec.sv
// Hex nibble to seven-segment decode.
// Purely combinational, logical levels (1 = on).
module my_seg7_dec
  import my_seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup from the shared pattern header.
  always_comb begin
    seg_o = seg7_hex(nib_i);
  end

endmodule

// File: rtl/my_seg7_defs.vh
// Seven-segment hex patterns and active-level helper.
// Shared by every display block that drives segments.
`ifndef MY_SEG7_DEFS_VH
`define MY_SEG7_DEFS_VH

// Segment order {a,b,c,d,e,f,g}, a = MSB, 1 = segment on.
function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
  logic [6:0] s;
  case (nib)
    4'h0:    s = 7'b1111110;
    4'h1:    s = 7'b0110000;
    4'h2:    s = 7'b1101101;
    4'h3:    s = 7'b1111001;
    4'h4:    s = 7'b0110011;
    4'h5:    s = 7'b1011011;
    4'h6:    s = 7'b1011111;
    4'h7:    s = 7'b1110000;
    4'h8:    s = 7'b1111111;
    4'h9:    s = 7'b1111011;
    4'hA:    s = 7'b1110111;
    4'hB:    s = 7'b0011111;
    4'hC:    s = 7'b1001110;
    4'hD:    s = 7'b0111101;
    4'hE:    s = 7'b1001111;
    default: s = 7'b1000111;
  endcase
  return s;
endfunction

// Map logical "on" bits to the pin level of the panel.
function automatic logic [6:0] seg7_lvl(
  input logic [6:0] s,
  input bit         act_high
);
  return act_high ? s : ~s;
endfunction

`endif

// File: rtl/my_seg7_scan.sv
// Multiplexed N-digit seven-segment scanner.
// Frame-aligned snapshot, guard bands, PWM brightness.
module my_seg7_scan
  import my_seg7_pkg::*;
#(
  parameter int N            = 4,
  parameter int SLOT_W       = 10,
  parameter int GUARD        = 8,
  parameter bit SEG_ACT_HIGH = 1'b1,
  parameter bit DIG_ACT_HIGH = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  my_seg7_if.slave  bus
);

  localparam int IW = idx_w(N);
  localparam logic [SLOT_W-1:0] CNT_MAX = '1;
  localparam logic [SLOT_W-1:0] G_LO =
    SLOT_W'(GUARD);
  localparam logic [SLOT_W-1:0] G_HI =
    SLOT_W'((1 << SLOT_W) - 1 - GUARD);
  localparam logic [IW-1:0] D_MAX = IW'(N - 1);
  localparam logic [6:0] SEG_OFF =
    seg7_lvl(7'd0, SEG_ACT_HIGH);
  localparam logic DP_OFF = ~SEG_ACT_HIGH;
  localparam logic [N-1:0] DIG_OFF =
    DIG_ACT_HIGH ? '0 : '1;

  logic [SLOT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]     d_q, d_d;
  logic [4*N-1:0]    num_q, num_d;
  logic [N-1:0]      dpin_q, dpin_d;
  logic              lzb_q, lzb_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [N-1:0]      dig_q, dig_d;
  logic              tick_q, tick_d;

  logic              last_cyc;
  logic              frame_end;
  logic              lit;
  logic [3:0]        nib;
  logic              dpsel;
  logic              hi_zero;
  logic              blank;
  logic [N-1:0]      oh;
  logic [6:0]        hex;

  my_seg7_dec u_dec (
    .nib_i (nib),
    .seg_o (hex)
  );

  // Select current digit data and detect zero upper nibbles.
  always_comb begin
    nib     = '0;
    dpsel   = 1'b0;
    hi_zero = 1'b1;
    oh      = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == d_q) begin
        nib   = num_q[4*k +: 4];
        dpsel = dpin_q[k];
        oh[k] = 1'b1;
      end
      if (IW'(k) >= d_q && num_q[4*k +: 4] != 4'd0)
        hi_zero = 1'b0;
    end
  end

  // Scan position, snapshot and next output values.
  always_comb begin
    last_cyc  = (cnt_q == CNT_MAX);
    frame_end = last_cyc && (d_q == D_MAX);
    lit = bus.en
      && (cnt_q >= G_LO)
      && (cnt_q <= G_HI)
      && (cnt_q[SLOT_W-1 -: 4] <= bus.bright);
    blank = lzb_q && (d_q != '0) && hi_zero;

    cnt_d = cnt_q + SLOT_W'(1);
    d_d   = d_q;
    if (last_cyc)
      d_d = (d_q == D_MAX) ? '0 : d_q + IW'(1);

    num_d  = num_q;
    dpin_d = dpin_q;
    lzb_d  = lzb_q;
    if (frame_end) begin
      num_d  = bus.num;
      dpin_d = bus.dp_in;
      lzb_d  = bus.lzb;
    end

    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    dig_d  = DIG_OFF;
    if (lit) begin
      seg_d = seg7_lvl(blank ? 7'd0 : hex,
                       SEG_ACT_HIGH);
      dp_d  = SEG_ACT_HIGH ? dpsel : ~dpsel;
      dig_d = DIG_ACT_HIGH ? oh : ~oh;
    end
    tick_d = frame_end;
  end

  // State and registered panel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      d_q    <= '0;
      num_q  <= '0;
      dpin_q <= '0;
      lzb_q  <= 1'b0;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      dig_q  <= DIG_OFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      num_q  <= num_d;
      dpin_q <= dpin_d;
      lzb_q  <= lzb_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.dig        = dig_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_my_seg7_scan.sv
// Self-checking bench for my_seg7_scan.
// N=4, SLOT_W=6, GUARD=2, random + directed.
module tb_my_seg7_scan;

  logic clk = 1'b0;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;

  my_seg7_if #(.N(4)) bus ();

  my_seg7_scan #(
    .N(4), .SLOT_W(6), .GUARD(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference: frame position 0..255 = digit*64 + slot cycle.
  int         pos;
  logic [15:0] sn_num;
  logic [3:0]  sn_dp;
  logic        sn_lz;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_tick;

  function automatic bit mlit(int p, logic e, logic [3:0] b);
    int c;
    c = p % 64;
    return e && c >= 2 && c < 62 && (c / 4) <= int'(b);
  endfunction

  function automatic logic [6:0] mseg(int dg, logic [15:0] n,
                                      logic lz);
    logic [15:0] hi;
    hi = n >> (4 * dg);
    if (lz && dg > 0 && hi == 16'd0) return 7'd0;
    return PAT[hi[3:0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pos    <= 0;
      sn_num <= '0;
      sn_dp  <= '0;
      sn_lz  <= 1'b0;
      e_seg  <= '0;
      e_dp   <= 1'b0;
      e_dig  <= 4'b1111;
      e_tick <= 1'b0;
    end else begin
      e_tick <= (pos == 255);
      if (mlit(pos, bus.en, bus.bright)) begin
        e_seg <= mseg(pos / 64, sn_num, sn_lz);
        e_dp  <= sn_dp[pos / 64];
        e_dig <= ~(4'b0001 << (pos / 64));
      end else begin
        e_seg <= '0;
        e_dp  <= 1'b0;
        e_dig <= 4'b1111;
      end
      pos <= (pos + 1) % 256;
      if (pos == 255) begin
        sn_num <= bus.num;
        sn_dp  <= bus.dp_in;
        sn_lz  <= bus.lzb;
      end
    end
  end

  task automatic wait_tick(output bit ok);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_tick && k < 400);
    ok = bus.frame_tick;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nchk++;
    if ({bus.seg, bus.dp, bus.dig, bus.frame_tick}
        !== 13'b0000000_0_1111_0) begin
      nerr++;
      $display("FAIL reset got=%b %b %b %b want=0000000 0 1111 0",
               bus.seg, bus.dp, bus.dig, bus.frame_tick);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      nchk++;
      if ({bus.seg, bus.dp, bus.dig, bus.frame_tick} !==
          {e_seg, e_dp, e_dig, e_tick}) begin
        nerr++;
        $display("FAIL reset_model got=%b %b %b %b want=%b %b %b %b",
                 bus.seg, bus.dp, bus.dig, bus.frame_tick,
                 e_seg, e_dp, e_dig, e_tick);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lit_cnt [4];
    int ticks;
    logic [6:0] want [4];
    want = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    bus.num = 16'h1234; bus.dp_in = 4'b0000;
    bus.bright = 4'd15; bus.lzb = 1'b0; bus.en = 1'b1;
    wait_tick(ok);
    nchk++;
    if (!ok) begin nerr++; $display("FAIL basic_tick timeout"); end
    foreach (lit_cnt[i]) lit_cnt[i] = 0;
    ticks = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (bus.frame_tick) ticks++;
      nchk++;
      if ({bus.seg, bus.dp, bus.dig, bus.frame_tick} !==
          {e_seg, e_dp, e_dig, e_tick}) begin
        nerr++;
        $display("FAIL basic_model got=%b %b %b %b want=%b %b %b %b",
                 bus.seg, bus.dp, bus.dig, bus.frame_tick,
                 e_seg, e_dp, e_dig, e_tick);
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.dig == ~(4'b0001 << k)) begin
          lit_cnt[k]++;
          nchk++;
          if (bus.seg !== want[k]) begin
            nerr++;
            $display("FAIL basic_seg d%0d got=%b want=%b",
                     k, bus.seg, want[k]);
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (lit_cnt[k] != 60) begin
        nerr++;
        $display("FAIL basic_lit d%0d got=%0d want=60",
                 k, lit_cnt[k]);
      end
    end
    nchk++;
    if (ticks != 1 || bus.frame_tick !== 1'b1) begin
      nerr++;
      $display("FAIL basic_period got=%0d last=%b want=1 last=1",
               ticks, bus.frame_tick);
    end
  endtask

  task automatic test_bright();
    bit ok;
    int lit_cnt;
    int bv [3] = '{0, 7, 3};
    int bw [3] = '{2, 30, 14};
    for (int t = 0; t < 3; t++) begin
      bus.bright = 4'(bv[t]);
      wait_tick(ok);
      nchk++;
      if (!ok) begin nerr++; $display("FAIL bright_tick timeout"); end
      lit_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        if (bus.dig == 4'b1101) lit_cnt++;
        nchk++;
        if ({bus.seg, bus.dp, bus.dig, bus.frame_tick} !==
            {e_seg, e_dp, e_dig, e_tick}) begin
          nerr++;
          $display("FAIL bright_model got=%b %b want=%b %b",
                   bus.seg, bus.dig, e_seg, e_dig);
        end
      end
      nchk++;
      if (lit_cnt != bw[t]) begin
        nerr++;
        $display("FAIL bright_%0d got=%0d want=%0d",
                 bv[t], lit_cnt, bw[t]);
      end
    end
    bus.bright = 4'd15;
  endtask

  task automatic test_lzb();
    bit ok;
    logic [6:0] ws [4];
    logic       wd [4];
    ws = '{7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000};
    wd = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus.num = 16'h0070; bus.lzb = 1'b1; bus.dp_in = 4'b1000;
    wait_tick(ok);
    nchk++;
    if (!ok) begin nerr++; $display("FAIL lzb_tick timeout"); end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (bus.dig == ~(4'b0001 << k)) begin
          nchk++;
          if ({bus.seg, bus.dp} !== {ws[k], wd[k]}) begin
            nerr++;
            $display("FAIL lzb d%0d got=%b %b want=%b %b",
                     k, bus.seg, bus.dp, ws[k], wd[k]);
          end
        end
      end
    end
    bus.lzb = 1'b0; bus.dp_in = 4'b0000;
  endtask

  task automatic test_tearing();
    bit ok;
    bus.num = 16'h1111;
    wait_tick(ok);
    wait_tick(ok);
    nchk++;
    if (!ok) begin nerr++; $display("FAIL tear_tick timeout"); end
    repeat (74) @(negedge clk);
    bus.num = 16'h2222;
    for (int f = 0; f < 2; f++) begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (bus.dig != 4'b1111) begin
          nchk++;
          if (bus.seg !== (f == 0 ? 7'b0110000 : 7'b1101101)) begin
            nerr++;
            $display("FAIL tear_f%0d got=%b dig=%b", f,
                     bus.seg, bus.dig);
          end
        end
      end while (!bus.frame_tick && k < 400);
      nchk++;
      if (!bus.frame_tick) begin
        nerr++;
        $display("FAIL tear_tick timeout f%0d", f);
      end
    end
  endtask

  task automatic test_rst_en();
    bit ok;
    wait_tick(ok);
    nchk++;
    if (!ok) begin nerr++; $display("FAIL rst_tick timeout"); end
    repeat (148) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nchk++;
    if ({bus.seg, bus.dig, bus.frame_tick} !== 12'b0000000_1111_0) begin
      nerr++;
      $display("FAIL rst_mid got=%b %b want=0000000 1111",
               bus.seg, bus.dig);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      nchk++;
      if (bus.dig !== 4'b1111) begin
        nerr++;
        $display("FAIL rst_dark got=%b want=1111", bus.dig);
      end
    end
    @(negedge clk);
    nchk++;
    if ({bus.seg, bus.dig} !== 11'b1111110_1110) begin
      nerr++;
      $display("FAIL rst_first got=%b %b want=1111110 1110",
               bus.seg, bus.dig);
    end
    repeat (20) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    nchk++;
    if ({bus.seg, bus.dig} !== 11'b0000000_1111) begin
      nerr++;
      $display("FAIL en_off got=%b %b want=0000000 1111",
               bus.seg, bus.dig);
    end
    for (int i = 0; i < 360; i++) begin
      if (i == 64) bus.en = 1'b1;
      @(negedge clk);
      nchk++;
      if ({bus.seg, bus.dp, bus.dig, bus.frame_tick} !==
          {e_seg, e_dp, e_dig, e_tick}) begin
        nerr++;
        $display("FAIL en_model got=%b %b %b want=%b %b %b",
                 bus.seg, bus.dig, bus.frame_tick,
                 e_seg, e_dig, e_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      nchk++;
      if ({bus.seg, bus.dp, bus.dig, bus.frame_tick} !==
          {e_seg, e_dp, e_dig, e_tick}) begin
        nerr++;
        $display("FAIL rand_model i=%0d got=%b %b %b %b want=%b %b %b %b",
                 i, bus.seg, bus.dp, bus.dig, bus.frame_tick,
                 e_seg, e_dp, e_dig, e_tick);
      end
      case ($urandom_range(0, 39))
        0: bus.num    = 16'($urandom);
        1: bus.num    = 16'($urandom_range(0, 255));
        2: bus.dp_in  = 4'($urandom);
        3: bus.lzb    = 1'($urandom);
        4: bus.bright = 4'($urandom);
        5: bus.en     = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.num = 16'hFFFF; bus.dp_in = 4'hF;
    bus.bright = 4'd15; bus.lzb = 1'b1;
    test_reset();
    test_basic();
    test_bright();
    test_lzb();
    test_tearing();
    test_rst_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
